// File: rtl/prog_up_down_counter_pkg.sv
// Shared definitions for the up/down counter: direction and overflow-policy
// encodings, plus the event record produced by the next-state calculator.
package prog_up_down_counter_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  localparam logic SAT_WRAP  = 1'b0;
  localparam logic SAT_CLAMP = 1'b1;

  // Boundary events raised by one step. The matching next count travels beside
  // this record on its own port because its width depends on the counter width.
  typedef struct packed {
    logic ovf;
    logic unf;
  } updn_evt_t;

endpackage

// File: rtl/prog_up_down_counter_next_calc.sv
// Combinational next-count calculator: one up or down step of size step_i
// within 0..limit_i, applying the wrap or saturate policy at the bounds.
module updown_next_calc
  import prog_up_down_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] step_i,
  input  logic [N-1:0] limit_i,
  input  logic         mode_i,
  input  logic         sat_i,
  output logic [N-1:0] next_q_o,
  output updn_evt_t    evt_o
);

  logic [N:0]   sum;
  logic [N-1:0] diff;
  logic [N-1:0] clamp_q;

  always_comb begin
    sum      = {1'b0, q_i} + {1'b0, step_i};
    diff     = q_i - step_i;
    clamp_q  = (q_i > limit_i) ? limit_i : q_i;
    next_q_o = q_i;
    evt_o    = '0;

    // A zero step never counts as a boundary crossing, even when Q sits above
    // a freshly lowered limit; Q is only pulled back into range.
    if (step_i == '0) begin
      next_q_o = clamp_q;
    end else if (mode_i == MODE_UP) begin
      if (sum <= {1'b0, limit_i}) begin
        next_q_o = sum[N-1:0];
      end else begin
        evt_o.ovf = 1'b1;
        next_q_o  = (sat_i == SAT_CLAMP) ? limit_i : '0;
      end
    end else begin
      if (step_i > q_i) begin
        evt_o.unf = 1'b1;
        next_q_o  = (sat_i == SAT_CLAMP) ? '0 : limit_i;
      end else begin
        next_q_o  = (diff > limit_i) ? limit_i : diff;
      end
    end
  end

endmodule

// File: rtl/prog_up_down_counter.sv
// Programmable up/down counter: runtime limit and step, parallel load,
// wrap/saturate policy, registered carry/borrow pulses, combinational bound flags.
module prog_up_down_counter
  import prog_up_down_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic [N-1:0] limit,
  input  logic [N-1:0] step,
  input  logic         sat,
  output logic         cout,
  output logic         bout,
  output logic [N-1:0] Q,
  output logic         at_max,
  output logic         at_min
);

  logic [N-1:0] q_q, q_d;
  logic         cout_q, cout_d;
  logic         bout_q, bout_d;
  logic [N-1:0] calc_q;
  updn_evt_t    calc_evt;

  updown_next_calc #(.N(N)) u_calc (
    .q_i      (q_q),
    .step_i   (step),
    .limit_i  (limit),
    .mode_i   (mode),
    .sat_i    (sat),
    .next_q_o (calc_q),
    .evt_o    (calc_evt)
  );

  // Load beats enable and suppresses both event pulses for that edge.
  always_comb begin
    q_d    = q_q;
    cout_d = 1'b0;
    bout_d = 1'b0;
    if (load) begin
      q_d = (din > limit) ? limit : din;
    end else if (enable) begin
      q_d    = calc_q;
      cout_d = calc_evt.ovf;
      bout_d = calc_evt.unf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      cout_q <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
      bout_q <= bout_d;
    end
  end

  assign Q      = q_q;
  assign cout   = cout_q;
  assign bout   = bout_q;
  assign at_max = (q_q == limit);
  assign at_min = (q_q == '0);

endmodule

// File: tb/tb_prog_up_down_counter.sv
// Directed-vector bench for prog_up_down_counter: the stimulus thread queues
// hand-computed expectations, a monitor pops and compares one per clock edge.
module tb_prog_up_down_counter;

  logic       clk = 1'b0;
  logic       reset, enable, mode, load, sat;
  logic [3:0] din, limit, step;
  logic       cout, bout, at_max, at_min;
  logic [3:0] Q;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       cout;
    logic       bout;
    logic       at_max;
    logic       at_min;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  prog_up_down_counter #(.N(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .load   (load),
    .din    (din),
    .limit  (limit),
    .step   (step),
    .sat    (sat),
    .cout   (cout),
    .bout   (bout),
    .Q      (Q),
    .at_max (at_max),
    .at_min (at_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One clocked vector: drive between edges, queue what the next edge must show.
  task automatic cyc(input string name, input logic ld, input logic en,
                     input logic md, input logic [3:0] d, input logic [3:0] lim,
                     input logic [3:0] stp, input logic s,
                     input logic [3:0] eq, input logic ec, input logic eb);
    exp_t e;
    @(negedge clk);
    reset = 1'b0; load = ld; enable = en; mode = md;
    din = d; limit = lim; step = stp; sat = s;
    e.name = name; e.q = eq; e.cout = ec; e.bout = eb;
    e.at_max = (eq == lim); e.at_min = (eq == 4'd0);
    exp_q.push_back(e);
  endtask

  // Monitor: the counter presents a new result every edge; compare one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".Q"},      int'(Q),      int'(e.q));
        check({e.name, ".cout"},   int'(cout),   int'(e.cout));
        check({e.name, ".bout"},   int'(bout),   int'(e.bout));
        check({e.name, ".at_max"}, int'(at_max), int'(e.at_max));
        check({e.name, ".at_min"}, int'(at_min), int'(e.at_min));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b1; load = 1'b0; sat = 1'b0;
    din = 4'd0; limit = 4'd9; step = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.Q", int'(Q), 0);
    check("rst.cout", int'(cout), 0);
    check("rst.bout", int'(bout), 0);

    // Count up to 5, then assert reset between edges.
    for (int i = 1; i <= 5; i++)
      cyc("cnt", 0, 1, 1, 0, 9, 1, 0, 4'(i), 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst.Q", int'(Q), 0);
    check("arst.cout", int'(cout), 0);
    check("arst.bout", int'(bout), 0);
    cyc("post_rst", 0, 1, 1, 0, 9, 1, 0, 4'd1, 0, 0);

    // Up wrap at limit 9, step 1.
    cyc("ld0", 1, 0, 1, 0, 9, 1, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 9; i++)
      cyc("upwrap", 0, 1, 1, 0, 9, 1, 0, 4'(i), 0, 0);
    cyc("wrap_ovf", 0, 1, 1, 0, 9, 1, 0, 4'd0, 1, 0);
    cyc("wrap_after", 0, 1, 1, 0, 9, 1, 0, 4'd1, 0, 0);

    // Step 3 with overflow, then load 8 and overflow from there.
    cyc("ld0b", 1, 0, 1, 0, 9, 3, 0, 4'd0, 0, 0);
    cyc("s3_a", 0, 1, 1, 0, 9, 3, 0, 4'd3, 0, 0);
    cyc("s3_b", 0, 1, 1, 0, 9, 3, 0, 4'd6, 0, 0);
    cyc("s3_c", 0, 1, 1, 0, 9, 3, 0, 4'd9, 0, 0);
    cyc("s3_ovf", 0, 1, 1, 0, 9, 3, 0, 4'd0, 1, 0);
    cyc("s3_d", 0, 1, 1, 0, 9, 3, 0, 4'd3, 0, 0);
    cyc("ld8", 1, 1, 1, 8, 9, 3, 0, 4'd8, 0, 0);
    cyc("s3_ovf8", 0, 1, 1, 0, 9, 3, 0, 4'd0, 1, 0);

    // Down saturate, step 2.
    cyc("ld3", 1, 0, 0, 3, 9, 2, 1, 4'd3, 0, 0);
    cyc("dsat_a", 0, 1, 0, 0, 9, 2, 1, 4'd1, 0, 0);
    cyc("dsat_unf", 0, 1, 0, 0, 9, 2, 1, 4'd0, 0, 1);
    cyc("dsat_unf2", 0, 1, 0, 0, 9, 2, 1, 4'd0, 0, 1);
    cyc("hold", 0, 0, 0, 0, 9, 2, 1, 4'd0, 0, 0);

    // Load priority over enable, load clamp to limit.
    cyc("ld12", 1, 1, 1, 12, 9, 1, 0, 4'd9, 0, 0);
    cyc("ld4", 1, 1, 1, 4, 9, 1, 0, 4'd4, 0, 0);

    // Direction turn right after a carry.
    cyc("ld8b", 1, 0, 1, 8, 9, 1, 0, 4'd8, 0, 0);
    cyc("turn_a", 0, 1, 1, 0, 9, 1, 0, 4'd9, 0, 0);
    cyc("turn_ovf", 0, 1, 1, 0, 9, 1, 0, 4'd0, 1, 0);
    cyc("turn_unf", 0, 1, 0, 0, 9, 1, 0, 4'd9, 0, 1);
    cyc("turn_b", 0, 1, 0, 0, 9, 1, 0, 4'd8, 0, 0);
    cyc("turn_c", 0, 1, 0, 0, 9, 1, 0, 4'd7, 0, 0);

    // Limit lowered below Q: up step overflows, down step clamps.
    cyc("lowlim_up", 0, 1, 1, 0, 5, 1, 0, 4'd0, 1, 0);
    cyc("ld5", 1, 0, 1, 5, 9, 1, 0, 4'd5, 0, 0);
    cyc("lowlim_dn", 0, 1, 0, 0, 3, 1, 0, 4'd3, 0, 0);

    // Zero step: hold with clamp, no events; saturate up at the bound.
    cyc("ld7", 1, 0, 1, 7, 9, 0, 0, 4'd7, 0, 0);
    cyc("step0", 0, 1, 1, 0, 5, 0, 0, 4'd5, 0, 0);
    cyc("usat", 0, 1, 1, 0, 5, 1, 1, 4'd5, 1, 0);

    // limit == 0: every step is a boundary event and Q stays 0.
    cyc("lim0_ld", 1, 0, 1, 6, 0, 2, 0, 4'd0, 0, 0);
    cyc("lim0_up", 0, 1, 1, 0, 0, 2, 0, 4'd0, 1, 0);
    cyc("lim0_dn", 0, 1, 0, 0, 0, 2, 0, 4'd0, 0, 1);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
